// File: rtl/noc_serial_receiver.sv
// Reassembles a header + NFLITS data-flit stream into one packet word behind a held output register.
// Latency: last flit accepted at cycle N -> out_valid at N+1; only the final flit stalls while the output is held.
module noc_serial_receiver #(
    parameter int PACKET_BITS    = 32,
    parameter int PADDING_BITS   = 0,
    parameter int FLIT_DATA_BITS = 32,
    parameter int ADDR_BITS      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_head,
    input  logic                      in_tail,
    input  logic [FLIT_DATA_BITS-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACKET_BITS-1:0]    out_packet,
    output logic [ADDR_BITS-1:0]      out_src,
    output logic                      err_proto,
    output logic [15:0]               pkt_count
);

    localparam int TOTAL    = PACKET_BITS + PADDING_BITS;
    localparam int NFLITS   = (TOTAL + FLIT_DATA_BITS - 1) / FLIT_DATA_BITS;
    localparam int ASM_BITS = NFLITS * FLIT_DATA_BITS;
    localparam int CNT_BITS = (NFLITS > 1) ? $clog2(NFLITS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NFLITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t                  state_q,      state_d;
    logic [CNT_BITS-1:0]     cnt_q,        cnt_d;
    logic [ASM_BITS-1:0]     asm_q,        asm_d;
    logic [ADDR_BITS-1:0]    src_stage_q,  src_stage_d;
    logic                    out_valid_q,  out_valid_d;
    logic [PACKET_BITS-1:0]  out_packet_q, out_packet_d;
    logic [ADDR_BITS-1:0]    out_src_q,    out_src_d;
    logic                    err_q,        err_d;
    logic [15:0]             pkt_count_q,  pkt_count_d;

    logic is_last;
    logic stall_last;
    logic accept;

    assign is_last    = (cnt_q == LAST_CNT);
    // The final flit would overwrite the held output, so it alone waits for the consumer.
    assign stall_last = (state_q == S_COLLECT) && is_last && out_valid_q && !out_ready;
    assign in_ready   = !flush && !stall_last;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        src_stage_d  = src_stage_q;
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        out_src_d    = out_src_q;
        err_d        = 1'b0;
        pkt_count_d  = pkt_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (in_head) begin
                        src_stage_d = in_data[ADDR_BITS-1:0];
                        cnt_d       = '0;
                        state_d     = S_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (in_head) begin
                        // Abandon the partial packet and restart on this header.
                        err_d       = 1'b1;
                        src_stage_d = in_data[ADDR_BITS-1:0];
                        cnt_d       = '0;
                    end else if (in_tail != is_last) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        for (int i = 0; i < NFLITS; i++) begin
                            if (cnt_q == CNT_BITS'(i)) begin
                                asm_d[i*FLIT_DATA_BITS +: FLIT_DATA_BITS] = in_data;
                            end
                        end
                        if (is_last) begin
                            state_d      = S_IDLE;
                            cnt_d        = '0;
                            out_valid_d  = 1'b1;
                            out_packet_d = asm_d[PACKET_BITS-1:0];
                            out_src_d    = src_stage_q;
                            pkt_count_d  = pkt_count_q + 16'd1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            asm_q        <= '0;
            src_stage_q  <= '0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            out_src_q    <= '0;
            err_q        <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            src_stage_q  <= src_stage_d;
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            out_src_q    <= out_src_d;
            err_q        <= err_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign out_src    = out_src_q;
    assign err_proto  = err_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_noc_serial_receiver.sv
// Bench for noc_serial_receiver in a 3-flit configuration (40-bit packet, 8 padding bits, 16-bit flits).
module tb_noc_serial_receiver;

    localparam int PB  = 40;
    localparam int PAD = 8;
    localparam int FDB = 16;
    localparam int AB  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic           in_head;
    logic           in_tail;
    logic [FDB-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [PB-1:0]  out_packet;
    logic [AB-1:0]  out_src;
    logic           err_proto;
    logic [15:0]    pkt_count;

    always #5 clk = ~clk;

    noc_serial_receiver #(
        .PACKET_BITS(PB), .PADDING_BITS(PAD), .FLIT_DATA_BITS(FDB), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_head(in_head), .in_tail(in_tail), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet), .out_src(out_src),
        .err_proto(err_proto), .pkt_count(pkt_count)
    );

    typedef logic [AB+PB-1:0] exp_t;
    exp_t sb[$];

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          err_seen     = 0;
    logic [15:0] exp_cnt      = '0;

    // Scoreboard: every handshake seen on the output pops one expected {src, packet}.
    always @(negedge clk) begin
        if (err_proto === 1'b1) err_seen++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard: unexpected packet src=%h pkt=%h", out_src, out_packet);
            end else begin
                e = sb.pop_front();
                if ({out_src, out_packet} !== e) begin
                    tests_failed++;
                    $display("FAIL scoreboard: got src=%h pkt=%h expected src=%h pkt=%h",
                             out_src, out_packet, e[AB+PB-1:PB], e[PB-1:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_flit(input logic h, input logic t, input logic [FDB-1:0] d);
        logic acc;
        int   n;
        in_valid = 1'b1; in_head = h; in_tail = t; in_data = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
        tests_run++;
        if (!acc) begin
            tests_failed++;
            $display("FAIL send_flit: flit %h not accepted within %0d cycles", d, n);
        end
    endtask

    task automatic send_stream(input logic [AB-1:0] src, input logic [47:0] w, input bit expect_ok);
        if (expect_ok) sb.push_back({src, w[PB-1:0]});
        send_flit(1'b1, 1'b0, {12'hABC, src});
        send_flit(1'b0, 1'b0, w[15:0]);
        send_flit(1'b0, 1'b0, w[31:16]);
        send_flit(1'b0, 1'b1, w[47:32]);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d packets still expected, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        tests_run += 6;
        if (out_valid !== 1'b0)     begin tests_failed++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        if (out_packet !== '0)      begin tests_failed++; $display("FAIL reset_out_packet: got %h required 0", out_packet); end
        if (out_src !== '0)         begin tests_failed++; $display("FAIL reset_out_src: got %h required 0", out_src); end
        if (err_proto !== 1'b0)     begin tests_failed++; $display("FAIL reset_err_proto: got %b required 0", err_proto); end
        if (pkt_count !== 16'd0)    begin tests_failed++; $display("FAIL reset_pkt_count: got %0d required 0", pkt_count); end
        if (in_ready !== 1'b1)      begin tests_failed++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        int e0 = err_seen;
        out_ready = 1'b0;
        sb.push_back({4'd5, 40'h5511223344});
        send_flit(1'b1, 1'b0, 16'h0005);
        send_flit(1'b0, 1'b0, 16'h3344);
        send_flit(1'b0, 1'b0, 16'h1122);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
        send_flit(1'b0, 1'b1, 16'hAA55);
        exp_cnt++;
        tests_run += 4;
        if (out_valid !== 1'b1)            begin tests_failed++; $display("FAIL basic_latency: out_valid %b required 1", out_valid); end
        if (out_packet !== 40'h5511223344) begin tests_failed++; $display("FAIL basic_packet: got %h required 5511223344", out_packet); end
        if (out_src !== 4'd5)              begin tests_failed++; $display("FAIL basic_src: got %h required 5", out_src); end
        if (pkt_count !== exp_cnt)         begin tests_failed++; $display("FAIL basic_count: got %0d required %0d", pkt_count, exp_cnt); end
        out_ready = 1'b1;
        step(1);
        tests_run += 2;
        if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL basic_consume: out_valid %b required 0", out_valid); end
        if (err_seen != e0)        begin tests_failed++; $display("FAIL basic_err: %0d pulses required 0", err_seen - e0); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_stream(4'd3, 48'h1234_5678_9ABC, 1'b1);
        exp_cnt++;
        sb.push_back({4'd6, 40'hDC_BA98_7654});
        send_flit(1'b1, 1'b0, 16'h0006);
        send_flit(1'b0, 1'b0, 16'h7654);
        send_flit(1'b0, 1'b0, 16'hBA98);
        in_valid = 1'b1; in_head = 1'b0; in_tail = 1'b1; in_data = 16'hFEDC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run += 2;
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_stall: in_ready %b required 0", in_ready); end
            if (out_packet !== 40'h345678_9ABC) begin tests_failed++; $display("FAIL bp_hold: got %h required 3456789abc", out_packet); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_flit(1'b0, 1'b1, 16'hFEDC);
        exp_cnt++;
        tests_run += 4;
        if (out_valid !== 1'b1)           begin tests_failed++; $display("FAIL bp_no_bubble: out_valid %b required 1", out_valid); end
        if (out_packet !== 40'hDCBA987654) begin tests_failed++; $display("FAIL bp_packet: got %h required dcba987654", out_packet); end
        if (out_src !== 4'd6)             begin tests_failed++; $display("FAIL bp_src: got %h required 6", out_src); end
        if (pkt_count !== exp_cnt)        begin tests_failed++; $display("FAIL bp_count: got %0d required %0d", pkt_count, exp_cnt); end
        drain();
    endtask

    task automatic test_tail_early();
        int e0 = err_seen;
        out_ready = 1'b1;
        send_flit(1'b1, 1'b0, 16'h0007);
        send_flit(1'b0, 1'b0, 16'h1111);
        send_flit(1'b0, 1'b1, 16'h2222);
        step(2);
        tests_run += 3;
        if (err_seen - e0 != 1)    begin tests_failed++; $display("FAIL tail_early_err: %0d pulses required 1", err_seen - e0); end
        if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL tail_early_valid: got %b required 0", out_valid); end
        if (pkt_count !== exp_cnt) begin tests_failed++; $display("FAIL tail_early_count: got %0d required %0d", pkt_count, exp_cnt); end
        send_stream(4'd9, 48'h0102_0304_0506, 1'b1);
        exp_cnt++;
        drain();
    endtask

    task automatic test_head_mid();
        int e0 = err_seen;
        out_ready = 1'b1;
        send_flit(1'b1, 1'b0, 16'h0002);
        send_flit(1'b0, 1'b0, 16'hAAAA);
        send_stream(4'hC, 48'h7777_8888_9999, 1'b1);
        exp_cnt++;
        drain();
        step(1);
        tests_run += 2;
        if (err_seen - e0 != 1)    begin tests_failed++; $display("FAIL head_mid_err: %0d pulses required 1", err_seen - e0); end
        if (pkt_count !== exp_cnt) begin tests_failed++; $display("FAIL head_mid_count: got %0d required %0d", pkt_count, exp_cnt); end
    endtask

    task automatic test_flush();
        int e0 = err_seen;
        out_ready = 1'b0;
        send_stream(4'd4, 48'h4444_3333_2222, 1'b0);
        exp_cnt++;
        send_flit(1'b1, 1'b0, 16'h0001);
        send_flit(1'b0, 1'b0, 16'h5555);
        in_valid = 1'b1; in_data = 16'h6666; flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        tests_run += 3;
        if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL flush_out_valid: got %b required 0", out_valid); end
        if (pkt_count !== exp_cnt) begin tests_failed++; $display("FAIL flush_count: got %0d required %0d", pkt_count, exp_cnt); end
        if (err_seen != e0)        begin tests_failed++; $display("FAIL flush_err: %0d pulses required 0", err_seen - e0); end
        out_ready = 1'b1;
        send_stream(4'd8, 48'hC0DE_BEEF_F00D, 1'b1);
        exp_cnt++;
        drain();
        tests_run++;
        if (pkt_count !== exp_cnt) begin tests_failed++; $display("FAIL flush_after_count: got %0d required %0d", pkt_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] w;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = {$urandom, $urandom};
            send_stream(4'(i + 10), w, 1'b1);
            exp_cnt++;
        end
        drain();
        tests_run++;
        if (pkt_count !== exp_cnt) begin tests_failed++; $display("FAIL b2b_count: got %0d required %0d", pkt_count, exp_cnt); end
    endtask

    task automatic test_rst_mid();
        int e0;
        out_ready = 1'b1;
        send_flit(1'b1, 1'b0, 16'h0003);
        send_flit(1'b0, 1'b0, 16'h1234);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_cnt = '0;
        e0 = err_seen;
        send_flit(1'b0, 1'b0, 16'h5678);
        send_flit(1'b0, 1'b1, 16'h9ABC);
        step(2);
        tests_run += 3;
        if (err_seen - e0 != 2)    begin tests_failed++; $display("FAIL rst_mid_err: %0d pulses required 2", err_seen - e0); end
        if (pkt_count !== exp_cnt) begin tests_failed++; $display("FAIL rst_mid_count: got %0d required 0", pkt_count); end
        if (out_valid !== 1'b0)    begin tests_failed++; $display("FAIL rst_mid_valid: got %b required 0", out_valid); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
        in_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_tail_early();
        test_head_mid();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL final_queue: %0d packets undelivered, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
